// File: rtl/image_pkg.sv
// Shared constants and FSM encoding for the double-buffered image frame writer.
package image_pkg;
    localparam int unsigned IMG_W     = 96;
    localparam int unsigned IMG_H     = 64;
    localparam int unsigned IMG_DEPTH = IMG_W * IMG_H;
    localparam int unsigned ADDR_W    = 13;
    localparam int unsigned PIX_W     = 16;

    typedef enum logic {
        StIdle = 1'b0,
        StRecv = 1'b1
    } state_t;
endpackage

// File: rtl/image_bram.sv
// Simple dual-port frame bank: synchronous write, registered synchronous read.
module image_bram
    import image_pkg::*;
#(
    parameter int unsigned DEPTH = IMG_DEPTH
) (
    input  logic              CLOCK,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [PIX_W-1:0]  wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [PIX_W-1:0]  rdata
);
    logic [PIX_W-1:0] mem [DEPTH];

    // Out-of-range reads hold the register; the top masks them to zero.
    always_ff @(posedge CLOCK) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (raddr < ADDR_W'(DEPTH)) begin
            rdata <= mem[raddr];
        end
    end
endmodule

// File: rtl/image_frame_writer.sv
// Double-buffered frame writer: fills one bank from a pixel stream while the
// display reads the other, swapping banks only when a frame completes.
module image_frame_writer
    import image_pkg::ADDR_W, image_pkg::PIX_W, image_pkg::state_t, image_pkg::StIdle,
           image_pkg::StRecv;
#(
    parameter int unsigned IMG_W = 96,
    parameter int unsigned IMG_H = 64
) (
    input  logic              CLOCK,
    input  logic              RESET_N,
    input  logic              sof,
    input  logic              pix_valid,
    input  logic [PIX_W-1:0]  pix_data,
    output logic              pix_ready,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [PIX_W-1:0]  rd_data,
    output logic              frame_done,
    output logic              frame_err,
    output logic              busy,
    output logic [ADDR_W-1:0] wr_count
);
    localparam int unsigned       DEPTH   = IMG_W * IMG_H;
    localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(DEPTH);

    state_t            state_q;
    logic              wr_bank_q;
    logic [ADDR_W-1:0] wr_count_q;
    logic              frame_done_q;
    logic              frame_err_q;
    logic              rd_valid_q;
    logic              rd_sel_q;
    logic              accept;
    logic [PIX_W-1:0]  rdata0;
    logic [PIX_W-1:0]  rdata1;

    assign busy       = (state_q == StRecv);
    assign pix_ready  = busy;
    assign accept     = pix_valid & pix_ready & ~sof;
    assign wr_count   = wr_count_q;
    assign frame_done = frame_done_q;
    assign frame_err  = frame_err_q;
    assign rd_data    = rd_valid_q ? (rd_sel_q ? rdata1 : rdata0) : '0;

    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q      <= StIdle;
            wr_bank_q    <= 1'b0;
            wr_count_q   <= '0;
            frame_done_q <= 1'b0;
            frame_err_q  <= 1'b0;
            rd_valid_q   <= 1'b0;
            rd_sel_q     <= 1'b0;
        end else begin
            frame_done_q <= 1'b0;
            frame_err_q  <= 1'b0;
            // Bank select is captured with the address, so a read on the swap
            // edge still returns the pre-swap display bank.
            rd_valid_q   <= (rd_addr < DEPTH_A);
            rd_sel_q     <= ~wr_bank_q;
            case (state_q)
                StIdle: begin
                    if (sof) begin
                        state_q    <= StRecv;
                        wr_count_q <= '0;
                    end
                end
                StRecv: begin
                    if (sof) begin
                        wr_count_q  <= '0;
                        frame_err_q <= 1'b1;
                    end else if (accept) begin
                        if (wr_count_q == LAST) begin
                            wr_count_q   <= '0;
                            wr_bank_q    <= ~wr_bank_q;
                            frame_done_q <= 1'b1;
                            state_q      <= StIdle;
                        end else begin
                            wr_count_q <= wr_count_q + ADDR_W'(1);
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    image_bram #(
        .DEPTH (DEPTH)
    ) u_bank0 (
        .CLOCK (CLOCK),
        .we    (accept & ~wr_bank_q),
        .waddr (wr_count_q),
        .wdata (pix_data),
        .raddr (rd_addr),
        .rdata (rdata0)
    );

    image_bram #(
        .DEPTH (DEPTH)
    ) u_bank1 (
        .CLOCK (CLOCK),
        .we    (accept & wr_bank_q),
        .waddr (wr_count_q),
        .wdata (pix_data),
        .raddr (rd_addr),
        .rdata (rdata1)
    );
endmodule

// File: doc/image_frame_writer.md
IMAGE_FRAME_WRITER -- requirements
Module: image_frame_writer

Interface
REQ-001 Parameter IMG_W, 96, pixels per line.
REQ-002 Parameter IMG_H, 64, lines per frame; DEPTH = IMG_W*IMG_H = 6144.
REQ-003 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-004 CLOCK  input  1  system clock; all state changes on its rising edge.
REQ-005 RESET_N  input  1  asynchronous active-low reset.
REQ-006 sof  input  1  start-of-frame strobe, one cycle.
REQ-007 pix_valid  input  1  pix_data holds a valid pixel.
REQ-008 pix_data  input  16  RGB565 pixel: [15:11] red, [10:5] green, [4:0] blue.
REQ-009 pix_ready  output  1  writer accepts a pixel this cycle.
REQ-010 rd_addr  input  13  display read address, row-major (y*IMG_W + x).
REQ-011 rd_data  output  16  pixel from the display bank.
REQ-012 frame_done  output  1  one-cycle pulse: frame complete, banks swapped.
REQ-013 frame_err  output  1  one-cycle pulse: frame aborted by early sof.
REQ-014 busy  output  1  high while in RECV.
REQ-015 wr_count  output  13  pixels accepted in the current frame.

Function
REQ-016 Storage SHALL be two banks of DEPTH x 16 bits. wr_bank receives writes; display bank = ~wr_bank.
REQ-017 FSM states: IDLE and RECV.
- IDLE --sof--> RECV, wr_count := 0.
- RECV --last pixel accepted--> IDLE.
- RECV --sof--> RECV (restart).
REQ-018 pix_ready SHALL be 1 only in RECV. A pixel is accepted when pix_valid & pix_ready & !sof.
REQ-019 On acceptance, mem[wr_bank][wr_count] := pix_data and wr_count += 1 at that edge.
REQ-020 When the accepted pixel has wr_count == DEPTH-1:
- the next edge SHALL toggle wr_bank, pulse frame_done for exactly 1 cycle, set wr_count := 0, and enter IDLE;
- no wrap-around write SHALL occur.
REQ-021 sof in RECV SHALL:
- drop the same-cycle pixel;
- set wr_count := 0 and stay in RECV;
- pulse frame_err for 1 cycle;
- leave the bank assignment unchanged.
REQ-022 sof in IDLE with pix_valid=1 SHALL NOT write that pixel; pix_ready is 0 in that cycle.
REQ-023 Read latency SHALL be exactly 1 cycle: rd_data at edge N+1 = display-bank[rd_addr sampled at edge N].
REQ-024 For rd_addr >= DEPTH, rd_data SHALL be 16'h0000 after the same latency.
REQ-025 A read in the cycle of a bank swap SHALL return data from the pre-swap display bank. The following read uses the new bank.
REQ-026 Reads SHALL never see partially written frames; the display bank is written only via the swap.
REQ-027 busy SHALL equal (state == RECV). wr_count SHALL be the registered counter.

Reset
REQ-028 RESET_N low SHALL immediately force:
- state = IDLE, wr_bank = 0, wr_count = 0;
- pix_ready = 0, frame_done = 0, frame_err = 0, busy = 0, rd_data = 0.
REQ-029 Memory contents SHALL NOT be reset. Reset mid-frame discards progress without a swap, and no frame_done or frame_err pulse is produced.
REQ-030 The block SHALL leave reset into IDLE and require a fresh sof.

Structure
REQ-031 A shared package image_pkg SHALL hold IMG_W, IMG_H, IMG_DEPTH, the 13-bit address width and the FSM state encoding.
REQ-032 Storage SHALL be one sub-module, image_bram: simple dual-port DEPTH x 16, sync write, sync registered read, instantiated twice (or once with bank as the address MSB).
REQ-033 Target size is 150-300 lines of RTL including image_bram.

Verification
REQ-034 Reset, then sof, then 6144 pixels with value = index, pix_valid always 1.
- frame_done pulses exactly once, 1 cycle after the 6144th accept; wr_count returns to 0.
- A read of rd_addr=100 returns 16'h0064 one cycle later.
REQ-035 Mid-frame sof after 500 pixels, then a full frame of 16'hF800.
- frame_err is a single pulse; the pixel in the sof cycle is dropped.
- After frame_done, all 6144 reads return 16'hF800.
REQ-036 Frame A (all 16'h07E0) completes; frame B (all 16'h001F) is half written.
- Reads return 16'h07E0 throughout B.
- After B's frame_done, reads return 16'h001F.
REQ-037 Reads with rd_addr = 6144 and 8191 return 16'h0000. A read issued on the swap edge returns the old bank's value.
REQ-038 Random pix_valid gaps (~30% idle): exactly 6144 writes, no duplicates or skips, wr_count monotonic. pix_valid in IDLE is ignored (pix_ready = 0).
REQ-039 RESET_N asserted at pixel 3000 mid-frame.
- Outputs are immediately 0 and no frame_done occurs.
- A following full frame completes normally, with frame_done after 6144 accepts.
